// File: rtl/pong_frame_renderer.sv
// Pong frame renderer: VGA timing, once-per-frame game-state snapshot, 2-stage pixel pipeline.
// Optional score bars on rows 4..11 are compiled in when SCORE_BARS_EN is defined.
module pong_frame_renderer #(
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter int P1_X    = 16,
   parameter int P2_X    = 616,
   parameter int PAD_W   = 8,
   parameter int BALL_SZ = 8,
   parameter int WALL_W  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] p1_y,
   input  logic [10:0] p2_y,
   input  logic [10:0] ball_x,
   input  logic [10:0] ball_y,
   input  logic [5:0]  p1_score,
   input  logic [5:0]  p2_score,
   input  logic [1:0]  mode,
   input  logic        bat_size,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        video_on,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_C = 11'(H_VIS);
   localparam logic [10:0] V_VIS_C = 11'(V_VIS);
   localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

   localparam logic [11:0] P1_X_C   = 12'(P1_X);
   localparam logic [11:0] P2_X_C   = 12'(P2_X);
   localparam logic [11:0] PAD_W_C  = 12'(PAD_W);
   localparam logic [11:0] BALL_C   = 12'(BALL_SZ);
   localparam logic [11:0] WALL_X_C = 12'(H_VIS - WALL_W);
   localparam logic [11:0] NET_L_C  = 12'(H_VIS / 2 - 1);
   localparam logic [11:0] NET_R_C  = 12'(H_VIS / 2);
   localparam logic [11:0] BAR2_END = 12'(H_VIS - 8);

   localparam logic [11:0] C_BALL = 12'hFF0;
   localparam logic [11:0] C_PAD  = 12'hFFF;
   localparam logic [11:0] C_WALL = 12'h00F;
   localparam logic [11:0] C_NET  = 12'h888;
   localparam logic [11:0] C_BAR1 = 12'hF00;
   localparam logic [11:0] C_BAR2 = 12'h0F0;
   localparam logic [11:0] C_BG   = 12'h000;

   // Widened to 12 bits so lo+len cannot wrap for objects near row 2047.
   function automatic logic in_span(input logic [11:0] pos, input logic [11:0] lo,
                                    input logic [11:0] len);
      return (pos >= lo) && (pos < lo + len);
   endfunction

   function automatic logic [11:0] pick_colour(input logic vis, input logic ball,
                                               input logic pad, input logic bar1,
                                               input logic bar2, input logic wall,
                                               input logic net);
      logic [11:0] c;
      c = C_BG;
      if (!vis)      c = C_BG;
      else if (ball) c = C_BALL;
      else if (bar1) c = C_BAR1;
      else if (bar2) c = C_BAR2;
      else if (pad)  c = C_PAD;
      else if (wall) c = C_WALL;
      else if (net)  c = C_NET;
      return c;
   endfunction

   logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic        vld_p0, hs_n_p0, vs_n_p0, snap_p0;
   logic        frame_tick_q, frame_tick_d;

   logic [10:0] p1_y_sh_q, p1_y_sh_d, p2_y_sh_q, p2_y_sh_d;
   logic [10:0] ball_x_sh_q, ball_x_sh_d, ball_y_sh_q, ball_y_sh_d;
   logic [1:0]  mode_sh_q, mode_sh_d;
   logic        bat_sh_q, bat_sh_d;
`ifdef SCORE_BARS_EN
   logic [5:0]  p1_score_sh_q, p1_score_sh_d, p2_score_sh_q, p2_score_sh_d;
`else
   logic        score_unused;
   assign score_unused = ^{p1_score, p2_score};
`endif

   logic        vld_p1_q, vld_p1_d, hs_n_p1_q, hs_n_p1_d, vs_n_p1_q, vs_n_p1_d;
   logic        ball_hit_p1_q, ball_hit_p1_d, pad_hit_p1_q, pad_hit_p1_d;
   logic        wall_hit_p1_q, wall_hit_p1_d, net_hit_p1_q, net_hit_p1_d;
   logic        bar1_hit_p1_q, bar1_hit_p1_d, bar2_hit_p1_q, bar2_hit_p1_d;

   logic [11:0] rgb_p2_q, rgb_p2_d;
   logic        vld_p2_q, vld_p2_d, hsync_p2_q, hsync_p2_d, vsync_p2_q, vsync_p2_d;

   logic [11:0] h12, v12, bat_len;
   logic [11:0] bar2_len;

   // Stage 0: raster counters, sync windows and the vblank snapshot strobe
   always_comb begin
      h_cnt_d = h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end
      vld_p0  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
      hs_n_p0 = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      vs_n_p0 = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
      snap_p0 = (h_cnt_q == '0) && (v_cnt_q == V_VIS_C);
      frame_tick_d = snap_p0;
   end

   always_comb begin
      p1_y_sh_d   = snap_p0 ? p1_y     : p1_y_sh_q;
      p2_y_sh_d   = snap_p0 ? p2_y     : p2_y_sh_q;
      ball_x_sh_d = snap_p0 ? ball_x   : ball_x_sh_q;
      ball_y_sh_d = snap_p0 ? ball_y   : ball_y_sh_q;
      mode_sh_d   = snap_p0 ? mode     : mode_sh_q;
      bat_sh_d    = snap_p0 ? bat_size : bat_sh_q;
`ifdef SCORE_BARS_EN
      p1_score_sh_d = snap_p0 ? p1_score : p1_score_sh_q;
      p2_score_sh_d = snap_p0 ? p2_score : p2_score_sh_q;
`endif
   end

   // Stage 1: hit tests against the shadowed game state
   always_comb begin
      h12     = {1'b0, h_cnt_q};
      v12     = {1'b0, v_cnt_q};
      bat_len = bat_sh_q ? 12'd96 : 12'd48;
      vld_p1_d  = vld_p0;
      hs_n_p1_d = hs_n_p0;
      vs_n_p1_d = vs_n_p0;
      ball_hit_p1_d = in_span(h12, {1'b0, ball_x_sh_q}, BALL_C) &&
                      in_span(v12, {1'b0, ball_y_sh_q}, BALL_C);
      pad_hit_p1_d  = (in_span(h12, P1_X_C, PAD_W_C) &&
                       in_span(v12, {1'b0, p1_y_sh_q}, bat_len)) ||
                      (!mode_sh_q[1] && in_span(h12, P2_X_C, PAD_W_C) &&
                       in_span(v12, {1'b0, p2_y_sh_q}, bat_len));
      wall_hit_p1_d = mode_sh_q[1] && (h12 >= WALL_X_C);
      net_hit_p1_d  = !mode_sh_q[1] && (h12 >= NET_L_C) && (h12 <= NET_R_C) && !v_cnt_q[4];
      bar1_hit_p1_d = 1'b0;
      bar2_hit_p1_d = 1'b0;
      bar2_len      = '0;
`ifdef SCORE_BARS_EN
      bar2_len = {4'b0, p2_score_sh_q, 2'b00};
      if ((v12 >= 12'd4) && (v12 < 12'd12)) begin
         bar1_hit_p1_d = in_span(h12, 12'd8, {4'b0, p1_score_sh_q, 2'b00});
         bar2_hit_p1_d = in_span(h12, BAR2_END - bar2_len, bar2_len);
      end
`endif
   end

   // Stage 2: colour resolve, with syncs and video_on delayed to match
   always_comb begin
      rgb_p2_d   = pick_colour(vld_p1_q, ball_hit_p1_q, pad_hit_p1_q, bar1_hit_p1_q,
                               bar2_hit_p1_q, wall_hit_p1_q, net_hit_p1_q);
      vld_p2_d   = vld_p1_q;
      hsync_p2_d = hs_n_p1_q;
      vsync_p2_d = vs_n_p1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         frame_tick_q  <= 1'b0;
         p1_y_sh_q     <= '0;
         p2_y_sh_q     <= '0;
         ball_x_sh_q   <= '0;
         ball_y_sh_q   <= '0;
         mode_sh_q     <= '0;
         bat_sh_q      <= 1'b0;
`ifdef SCORE_BARS_EN
         p1_score_sh_q <= '0;
         p2_score_sh_q <= '0;
`endif
         vld_p1_q      <= 1'b0;
         hs_n_p1_q     <= 1'b1;
         vs_n_p1_q     <= 1'b1;
         ball_hit_p1_q <= 1'b0;
         pad_hit_p1_q  <= 1'b0;
         wall_hit_p1_q <= 1'b0;
         net_hit_p1_q  <= 1'b0;
         bar1_hit_p1_q <= 1'b0;
         bar2_hit_p1_q <= 1'b0;
         rgb_p2_q      <= '0;
         vld_p2_q      <= 1'b0;
         hsync_p2_q    <= 1'b1;
         vsync_p2_q    <= 1'b1;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         frame_tick_q  <= frame_tick_d;
         p1_y_sh_q     <= p1_y_sh_d;
         p2_y_sh_q     <= p2_y_sh_d;
         ball_x_sh_q   <= ball_x_sh_d;
         ball_y_sh_q   <= ball_y_sh_d;
         mode_sh_q     <= mode_sh_d;
         bat_sh_q      <= bat_sh_d;
`ifdef SCORE_BARS_EN
         p1_score_sh_q <= p1_score_sh_d;
         p2_score_sh_q <= p2_score_sh_d;
`endif
         vld_p1_q      <= vld_p1_d;
         hs_n_p1_q     <= hs_n_p1_d;
         vs_n_p1_q     <= vs_n_p1_d;
         ball_hit_p1_q <= ball_hit_p1_d;
         pad_hit_p1_q  <= pad_hit_p1_d;
         wall_hit_p1_q <= wall_hit_p1_d;
         net_hit_p1_q  <= net_hit_p1_d;
         bar1_hit_p1_q <= bar1_hit_p1_d;
         bar2_hit_p1_q <= bar2_hit_p1_d;
         rgb_p2_q      <= rgb_p2_d;
         vld_p2_q      <= vld_p2_d;
         hsync_p2_q    <= hsync_p2_d;
         vsync_p2_q    <= vsync_p2_d;
      end
   end

   assign hsync      = hsync_p2_q;
   assign vsync      = vsync_p2_q;
   assign rgb        = rgb_p2_q;
   assign video_on   = vld_p2_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer; vertical timing is shortened (16 visible of 22 lines)
// so several frames fit in a short run. Horizontal timing is the standard 800-pixel line.
module tb_pong_frame_renderer;

   localparam int LINE  = 800;
   localparam int FRAME = LINE * 22;

`ifdef SCORE_BARS_EN
   localparam logic [11:0] EXP_16_9 = 12'hF00;
`else
   localparam logic [11:0] EXP_16_9 = 12'h000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] p1_y, p2_y, ball_x, ball_y;
   logic [5:0]  p1_score, p2_score;
   logic [1:0]  mode;
   logic        bat_size;
   logic        hsync, vsync, video_on, frame_tick;
   logic [11:0] rgb;

   int checks = 0;
   int errors = 0;
   int now    = 0;

   always #20 clk = ~clk;

   pong_frame_renderer #(
      .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut (
      .clk(clk), .rst(rst),
      .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
      .p1_score(p1_score), .p2_score(p2_score), .mode(mode), .bat_size(bat_size),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on), .frame_tick(frame_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Edge k counts posedges since the last reset edge; samples land on the following negedge.
   task automatic at_edge(input int k);
      if (k > now) begin
         repeat (k - now) @(posedge clk);
         now = k;
         @(negedge clk);
      end
   endtask

   // Counter value (h,v) of frame f appears on the outputs two edges later.
   task automatic pix(input int f, input int h, input int v, input logic [11:0] exp,
                      input string tag);
      at_edge(f * FRAME + v * LINE + h + 2);
      chk(tag, rgb, exp);
   endtask

   initial begin
      int low, first;
      mode = 2'b00; bat_size = 1'b1;
      ball_x = 11'd100; ball_y = 11'd4;
      p1_y = 11'd10; p2_y = 11'd2047;
      p1_score = 6'd5; p2_score = 6'd3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      now = 0;
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_rgb", rgb, 0);
      chk("rst_video_on", video_on, 0);
      chk("rst_tick", frame_tick, 0);

      // Frame 0 renders the zeroed shadows, not the inputs already applied.
      pix(0, 0, 0, 12'hFF0, "f0_ball_origin");
      pix(0, 16, 0, 12'hFFF, "f0_pad1_row0");
      pix(0, 616, 0, 12'hFFF, "f0_pad2_row0");
      at_edge(639 + 2);
      chk("vid_on_639", video_on, 1);
      at_edge(640 + 2);
      chk("vid_off_640", video_on, 0);
      chk("rgb_blank_640", rgb, 0);

      low = 0; first = -1;
      for (int h = 0; h < LINE; h++) begin
         at_edge(LINE + h + 2);
         if (hsync == 1'b0) begin
            low++;
            if (first < 0) first = h;
         end
      end
      chk("hsync_width", low, 96);
      chk("hsync_start", first, 656);
      pix(0, 7, 7, 12'hFF0, "f0_ball_corner");

      at_edge(16 * LINE);
      chk("tick_before", frame_tick, 0);
      at_edge(16 * LINE + 1);
      chk("tick_pulse", frame_tick, 1);
      at_edge(16 * LINE + 2);
      chk("tick_after", frame_tick, 0);

      at_edge(17 * LINE + 2);
      chk("vsync_l17", vsync, 1);
      at_edge(18 * LINE + 2);
      chk("vsync_l18", vsync, 0);
      at_edge(19 * LINE + 2);
      chk("vsync_l19", vsync, 0);
      at_edge(20 * LINE + 2);
      chk("vsync_l20", vsync, 1);

      // Frame 1: tennis, ball (100,4), large bat p1 at row 10, p2 at row 2047.
      pix(1, 319, 0, 12'h888, "net_319");
      pix(1, 616, 0, 12'h000, "p2_no_wrap_row0");
      pix(1, 318, 2, 12'h000, "net_left_edge");
      pix(1, 320, 2, 12'h888, "net_320");
      pix(1, 321, 2, 12'h000, "net_right_edge");
      pix(1, 99, 4, 12'h000, "ball_left_out");
      pix(1, 100, 4, 12'hFF0, "ball_tl");
`ifdef SCORE_BARS_EN
      pix(1, 8, 5, 12'hF00, "bar1_start");
      pix(1, 27, 5, 12'hF00, "bar1_end");
      pix(1, 28, 5, 12'h000, "bar1_past");
      pix(1, 108, 5, 12'h000, "ball_right_out");
      pix(1, 619, 5, 12'h000, "bar2_before");
      pix(1, 620, 5, 12'h0F0, "bar2_start");
      pix(1, 631, 5, 12'h0F0, "bar2_end");
      pix(1, 632, 5, 12'h000, "bar2_past");
`else
      pix(1, 108, 5, 12'h000, "ball_right_out");
`endif
      pix(1, 16, 9, EXP_16_9, "pad1_above");
      pix(1, 107, 11, 12'hFF0, "ball_br");
      pix(1, 100, 12, 12'h000, "ball_below");
      pix(1, 16, 13, 12'hFFF, "pad1_in");
      pix(1, 24, 13, 12'h000, "pad1_right_out");
      pix(1, 23, 15, 12'hFFF, "pad1_clip_last");
      pix(1, 616, 15, 12'h000, "p2_no_wrap_row15");

      mode = 2'b10; ball_x = 11'd630; p2_y = 11'd12;
      at_edge(FRAME + 16 * LINE);
      chk("tick2_before", frame_tick, 0);
      at_edge(FRAME + 16 * LINE + 1);
      chk("tick2_period", frame_tick, 1);

      // Frame 2: squash, ball overlapping the wall.
      pix(2, 319, 0, 12'h000, "sq_no_net");
      pix(2, 631, 0, 12'h000, "wall_before");
      pix(2, 632, 0, 12'h00F, "wall_start");
      pix(2, 639, 0, 12'h00F, "wall_end");
      pix(2, 630, 4, 12'hFF0, "ball_over_bar");
      pix(2, 637, 4, 12'hFF0, "ball_over_wall");
      pix(2, 638, 4, 12'h00F, "wall_after_ball");
      at_edge(2 * FRAME + 8 * LINE + 2);
      ball_x = 11'd200;
      pix(2, 200, 10, 12'h000, "midframe_new_absent");
      pix(2, 630, 10, 12'hFF0, "midframe_old_held");
      pix(2, 616, 13, 12'h000, "sq_no_p2");
      pix(2, 633, 13, 12'h00F, "wall_row13");

      // Frame 3: the mid-frame ball move takes effect.
      pix(3, 200, 4, 12'hFF0, "new_ball_shown");
      pix(3, 633, 4, 12'h00F, "old_ball_gone");

      at_edge(3 * FRAME + 5 * LINE + 700 + 2);
      chk("pre_rst_hsync", hsync, 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      now = 0;
      chk("mid_rst_hsync", hsync, 1);
      chk("mid_rst_vsync", vsync, 1);
      chk("mid_rst_video_on", video_on, 0);
      chk("mid_rst_tick", frame_tick, 0);
      pix(0, 0, 0, 12'hFF0, "mid_rst_restart");
      at_edge(16 * LINE);
      chk("mid_rst_no_early_tick", frame_tick, 0);
      at_edge(16 * LINE + 1);
      chk("mid_rst_tick_pulse", frame_tick, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
